// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: RV32I load/store initiator for a word-only data memory.
// Translates byte addresses to word indices and performs sub-word stores as
// read-modify-write. It sign/zero-extends load data and returns one response
// per request.
// Optional build macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned
// LW/SW/LH/LHU/SH are rejected. When it is undefined, the low address bits are
// forced to natural alignment.
module lsu_dmem_master #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          MEM_WORDS = 2000,
    parameter int          ADDR_W    = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_WRITE,
        S_RESP
    } state_t;

    state_t            state_q;
    logic              req_ready_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [1:0]        lane_q;
    logic [31:0]       wdata_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [31:0]       rsp_rdata_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    // Accept-time decode results.
    logic [31:0] off_d;
    logic [31:0] idx_d;
    logic [1:0]  lane_raw_d;
    logic [1:0]  lane_d;
    logic        is_word_d;
    logic        is_half_d;
    logic        f3_err_d;
    logic        range_err_d;
    logic        mis_err_d;
    logic        acc_err_d;

    // Capture-time data paths.
    logic [31:0] shifted_d;
    logic [7:0]  byte_d;
    logic [15:0] half_d;
    logic [31:0] ld_ext_d;
    logic [31:0] merged_d;

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Decode the incoming request: word index, lane and all rejection reasons.
    always_comb begin
        off_d       = req_addr - BASE_ADDR;  // wraps, so addresses below base become huge
        idx_d       = {2'b00, off_d[31:2]};
        lane_raw_d  = off_d[1:0];
        is_word_d   = (req_funct3[1:0] == 2'b10);
        is_half_d   = (req_funct3[1:0] == 2'b01);
        range_err_d = (idx_d >= MEM_WORDS_L);
        if (req_we) begin
            f3_err_d = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010);
        end else begin
            f3_err_d = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010 ||
                         req_funct3 == 3'b100 || req_funct3 == 3'b101);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        mis_err_d = (is_word_d && lane_raw_d != 2'b00) || (is_half_d && lane_raw_d[0]);
        lane_d    = lane_raw_d;
`else
        mis_err_d = 1'b0;
        if (is_word_d) begin
            lane_d = 2'b00;
        end else if (is_half_d) begin
            lane_d = {lane_raw_d[1], 1'b0};
        end else begin
            lane_d = lane_raw_d;
        end
`endif
        acc_err_d = range_err_d || f3_err_d || mis_err_d;
    end

    // Select and extend load data, and merge sub-word store data into the read word.
    always_comb begin
        shifted_d = mem_rdata >> {lane_q, 3'b000};
        byte_d    = shifted_d[7:0];
        half_d    = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext_d = {{24{byte_d[7]}}, byte_d};
            3'b001:  ld_ext_d = {{16{half_d[15]}}, half_d};
            3'b100:  ld_ext_d = {24'h0, byte_d};
            3'b101:  ld_ext_d = {16'h0, half_d};
            default: ld_ext_d = mem_rdata;
        endcase
        merged_d = mem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            merged_d[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged_d[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // Control FSM with registered outputs; one request in flight at a time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            lane_q      <= 2'b00;
            wdata_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        we_q        <= req_we;
                        funct3_q    <= req_funct3;
                        lane_q      <= lane_d;
                        wdata_q     <= req_wdata;
                        // Stores and errors respond with zero data; loads overwrite at capture.
                        rsp_rdata_q <= 32'h0;
                        if (acc_err_d) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state_q    <= S_ISSUE;
                            mem_en_q   <= 1'b1;
                            mem_addr_q <= idx_d[ADDR_W-1:0];
                            if (req_we && is_word_d) begin
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= req_wdata;
                            end else begin
                                mem_we_q <= 1'b0;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (mem_we_q) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (we_q) begin
                        state_q     <= S_WRITE;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= merged_d;
                    end else begin
                        state_q     <= S_RESP;
                        rsp_rdata_q <= ld_ext_d;
                        rsp_valid_q <= 1'b1;
                    end
                end
                S_WRITE: begin
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    state_q     <= S_RESP;
                    rsp_valid_q <= 1'b1;
                end
                S_RESP: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Testbench for lsu_dmem_master: table-driven request vectors against a
// behavioural word memory, plus a hand-written reset-during-write sequence.
module tb_lsu_dmem_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Backdoor preload port into the memory model.
    logic        bd_we;
    logic [10:0] bd_idx;
    logic [31:0] bd_val;
    logic [31:0] mem_model [0:2047];

    int checks;
    int errors;

    lsu_dmem_master dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous word memory with one-cycle read latency.
    always @(posedge clk) begin
        if (bd_we) begin
            mem_model[bd_idx] <= bd_val;
        end
        if (mem_en) begin
            if (mem_we) begin
                mem_model[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= mem_model[mem_addr];
            end
        end
    end

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        pre_en;
        logic [10:0] pre_idx;
        logic [31:0] pre_val;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_wk;
        logic [10:0] exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(string name, logic we, logic [2:0] f3, logic [31:0] addr,
                                logic [31:0] wdata, logic pre_en, logic [10:0] pre_idx,
                                logic [31:0] pre_val, int exp_lat, logic exp_err,
                                logic [31:0] exp_rdata, int exp_wk, logic [10:0] exp_waddr,
                                logic [31:0] exp_wdata);
        vec_t v;
        v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.pre_en = pre_en; v.pre_idx = pre_idx; v.pre_val = pre_val;
        v.exp_lat = exp_lat; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
        v.exp_wk = exp_wk; v.exp_waddr = exp_waddr; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic preload(logic [10:0] idx, logic [31:0] val);
        bd_we  = 1'b1;
        bd_idx = idx;
        bd_val = val;
        @(negedge clk);
        bd_we  = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        bd_we      = 1'b0;
        bd_idx     = '0;
        bd_val     = 32'h0;
        for (int i = 0; i < 2048; i++) mem_model[i] = 32'h0;

        // Reset state.
        #12;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_err",   {31'h0, rsp_err},   32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_mem_en",    {31'h0, mem_en},    32'h0);
        chk("rst_mem_we",    {31'h0, mem_we},    32'h0);
        chk("rst_mem_addr",  {21'h0, mem_addr},  32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        //          name       we    f3      addr          wdata         pre idx    preval        lat err rdata         wk waddr  wdata
        vq.push_back(mk("sw",      1'b1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 11'd0, 32'h0,        2, 1'b0, 32'h0,        1, 11'd4, 32'hDEAD_BEEF));
        vq.push_back(mk("lw_after_sw", 1'b0, 3'b010, 32'h8000_0010, 32'h0,   1'b0, 11'd0, 32'h0,        3, 1'b0, 32'hDEAD_BEEF, 0, 11'd0, 32'h0));
        vq.push_back(mk("lb",      1'b0, 3'b000, 32'h8000_0013, 32'h0,        1'b1, 11'd4, 32'h80FF_7F01, 3, 1'b0, 32'hFFFF_FF80, 0, 11'd0, 32'h0));
        vq.push_back(mk("lbu",     1'b0, 3'b100, 32'h8000_0013, 32'h0,        1'b0, 11'd0, 32'h0,        3, 1'b0, 32'h0000_0080, 0, 11'd0, 32'h0));
        vq.push_back(mk("lh",      1'b0, 3'b001, 32'h8000_0012, 32'h0,        1'b0, 11'd0, 32'h0,        3, 1'b0, 32'hFFFF_80FF, 0, 11'd0, 32'h0));
        vq.push_back(mk("lhu",     1'b0, 3'b101, 32'h8000_0010, 32'h0,        1'b0, 11'd0, 32'h0,        3, 1'b0, 32'h0000_7F01, 0, 11'd0, 32'h0));
        vq.push_back(mk("lb_pos",  1'b0, 3'b000, 32'h8000_0011, 32'h0,        1'b0, 11'd0, 32'h0,        3, 1'b0, 32'h0000_007F, 0, 11'd0, 32'h0));
        vq.push_back(mk("sb",      1'b1, 3'b000, 32'h8000_0011, 32'hFFFF_FFAB, 1'b1, 11'd4, 32'h1122_3344, 4, 1'b0, 32'h0,      3, 11'd4, 32'h1122_AB44));
        vq.push_back(mk("sh",      1'b1, 3'b001, 32'h8000_0012, 32'h1234_BEEF, 1'b1, 11'd4, 32'h1122_3344, 4, 1'b0, 32'h0,      3, 11'd4, 32'hBEEF_3344));
        vq.push_back(mk("err_low", 1'b0, 3'b010, 32'h7FFF_FFFC, 32'h0,        1'b0, 11'd0, 32'h0,        1, 1'b1, 32'h0,        0, 11'd0, 32'h0));
        vq.push_back(mk("err_idx2000", 1'b0, 3'b010, 32'h8000_1F40, 32'h0,    1'b0, 11'd0, 32'h0,        1, 1'b1, 32'h0,        0, 11'd0, 32'h0));
        vq.push_back(mk("lw_idx1999", 1'b0, 3'b010, 32'h8000_1F3C, 32'h0,     1'b1, 11'd1999, 32'h5A5A_0F0F, 3, 1'b0, 32'h5A5A_0F0F, 0, 11'd0, 32'h0));
        vq.push_back(mk("err_ld_f3_011", 1'b0, 3'b011, 32'h8000_0010, 32'h0,  1'b0, 11'd0, 32'h0,        1, 1'b1, 32'h0,        0, 11'd0, 32'h0));
        vq.push_back(mk("err_st_f3_100", 1'b1, 3'b100, 32'h8000_0010, 32'h0,  1'b0, 11'd0, 32'h0,        1, 1'b1, 32'h0,        0, 11'd0, 32'h0));
`ifdef LSU_MISALIGN_TRAP_EN
        vq.push_back(mk("lw_mis",  1'b0, 3'b010, 32'h8000_0002, 32'h0,        1'b1, 11'd0, 32'hCAFE_F00D, 1, 1'b1, 32'h0,        0, 11'd0, 32'h0));
        vq.push_back(mk("sh_mis",  1'b1, 3'b001, 32'h8000_0013, 32'h0000_1357, 1'b1, 11'd4, 32'h1122_3344, 1, 1'b1, 32'h0,      0, 11'd0, 32'h0));
`else
        vq.push_back(mk("lw_mis",  1'b0, 3'b010, 32'h8000_0002, 32'h0,        1'b1, 11'd0, 32'hCAFE_F00D, 3, 1'b0, 32'hCAFE_F00D, 0, 11'd0, 32'h0));
        vq.push_back(mk("sh_mis",  1'b1, 3'b001, 32'h8000_0013, 32'h0000_1357, 1'b1, 11'd4, 32'h1122_3344, 4, 1'b0, 32'h0,      3, 11'd4, 32'h1357_3344));
`endif

        foreach (vq[i]) begin
            vec_t v;
            int lat, wk, k;
            logic seen_err, mem_seen, done;
            logic [31:0] seen_rdata, wdata_seen;
            logic [10:0] waddr_seen;
            v = vq[i];
            @(negedge clk);
            if (v.pre_en) preload(v.pre_idx, v.pre_val);
            chk({v.name, "_ready"}, {31'h0, req_ready}, 32'h1);
            req_valid  = 1'b1;
            req_we     = v.we;
            req_funct3 = v.f3;
            req_addr   = v.addr;
            req_wdata  = v.wdata;
            @(negedge clk);
            // Junk on the request bus after acceptance must be ignored.
            req_valid  = 1'b0;
            req_we     = ~v.we;
            req_funct3 = 3'b111;
            req_addr   = 32'h8000_0100;
            req_wdata  = 32'h5555_5555;
            lat = 0; wk = 0; k = 1; done = 1'b0;
            seen_err = 1'b0; mem_seen = 1'b0; seen_rdata = 32'h0;
            waddr_seen = '0; wdata_seen = 32'h0;
            while (!done) begin
                if (mem_en) begin
                    mem_seen = 1'b1;
                    if (mem_we) begin
                        wk = k; waddr_seen = mem_addr; wdata_seen = mem_wdata;
                    end
                end
                if (rsp_valid) begin
                    lat = k; seen_err = rsp_err; seen_rdata = rsp_rdata; done = 1'b1;
                end else if (k >= 10) begin
                    done = 1'b1;
                end else begin
                    k++;
                    @(negedge clk);
                end
            end
            $display("txn %0s lat=%0d err=%0b rdata=%h wk=%0d waddr=%0d wdata=%h",
                     v.name, lat, seen_err, seen_rdata, wk, waddr_seen, wdata_seen);
            chk({v.name, "_latency"}, lat, v.exp_lat);
            chk({v.name, "_err"}, {31'h0, seen_err}, {31'h0, v.exp_err});
            chk({v.name, "_rdata"}, seen_rdata, v.exp_rdata);
            chk({v.name, "_write_cycle"}, wk, v.exp_wk);
            chk({v.name, "_mem_en_seen"}, {31'h0, mem_seen}, {31'h0, (v.exp_lat > 1)});
            if (v.exp_wk != 0) begin
                chk({v.name, "_waddr"}, {21'h0, waddr_seen}, {21'h0, v.exp_waddr});
                chk({v.name, "_wdata"}, wdata_seen, v.exp_wdata);
            end
            @(negedge clk);
            chk({v.name, "_pulse_end"}, {31'h0, rsp_valid}, 32'h0);
            if (v.exp_wk != 0) begin
                chk({v.name, "_memword"}, mem_model[v.exp_waddr], v.exp_wdata);
            end
        end

        // Reset asserted while an SB is in its WRITE cycle.
        @(negedge clk);
        preload(11'd4, 32'h1122_3344);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h8000_0011;
        req_wdata  = 32'h0000_0055;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstw_write_en", {31'h0, mem_en}, 32'h1);
        chk("rstw_write_we", {31'h0, mem_we}, 32'h1);
        chk("rstw_write_data", mem_wdata, 32'h1122_5544);
        #1 rst_n = 1'b0;
        #1;
        chk("rstw_mem_en_now", {31'h0, mem_en}, 32'h0);
        chk("rstw_ready_now", {31'h0, req_ready}, 32'h1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rstw_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rstw_rsp_valid_after", {31'h0, rsp_valid}, 32'h0);
        end
        chk("rstw_ready_after", {31'h0, req_ready}, 32'h1);
        chk("rstw_memword", mem_model[4], 32'h1122_3344);
        $display("txn reset_in_write mem_en=%0b ready=%0b word4=%h", mem_en, req_ready, mem_model[4]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
